// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared FSM state type and sizing constants for rom_arbiter.
package rom_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    localparam int NREQ = 2;
    localparam int STAT_W = 16;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    always_comb begin
        gnt_idx = (req == 2'b11) ? ~last : req[1];
        gnt = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between two valid/ready requesters, round-robin.
// Define ROM_ARBITER_STATS_EN to add saturating per-requester grant counters.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int N = 3,
    parameter int O = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [N-1:0]    req_addr0,
    input  logic [N-1:0]    req_addr1,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_ready,
    output logic [O-1:0]    rsp_data,
    output logic [N-1:0]    rom_addr,
    input  logic [O-1:0]    rom_data
`ifdef ROM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
`endif
);
    state_t state, state_n;
    logic grant, last_grant, gnt_idx, accept;
    logic [NREQ-1:0] gnt;

    rr_arb2 u_arb (
        .req(req_valid),
        .last(last_grant),
        .gnt(gnt),
        .gnt_idx(gnt_idx)
    );

    assign accept = (state == IDLE) && |req_valid;
    assign req_ready = (accept && !rst) ? gnt : '0;

    always_comb begin
        state_n = (state == IDLE) ? (accept ? READ : IDLE) :
                  (state == READ) ? RESP :
                  (state == RESP && !rsp_ready[grant]) ? RESP : IDLE;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                rom_addr <= gnt_idx ? req_addr1 : req_addr0;
                grant    <= gnt_idx;
            end
            if (state == READ) begin
                rsp_data         <= rom_data;
                rsp_valid[grant] <= 1'b1;
            end
            // only the granted requester's ready can retire the response
            if (state == RESP && rsp_ready[grant]) begin
                rsp_valid  <= '0;
                last_grant <= grant;
            end
        end
    end

`ifdef ROM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept && !gnt_idx && grant_cnt0 != '1)
                grant_cnt0 <= grant_cnt0 + 1'b1;
            if (accept && gnt_idx && grant_cnt1 != '1)
                grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif
endmodule
